// File: rtl/spigot_digit_sink_pkg.sv
// Shared types and constants for the spigot digit sink: digit width, the pi
// reference digits and the stream checker state encoding.
package spigot_pkg;

    localparam int DIGIT_W = 4;
    localparam int PI_LEN  = 32;

    localparam logic [DIGIT_W-1:0] PI_DIGITS [PI_LEN] = '{
        4'd3, 4'd1, 4'd4, 4'd1, 4'd5, 4'd9, 4'd2, 4'd6,
        4'd5, 4'd3, 4'd5, 4'd8, 4'd9, 4'd7, 4'd9, 4'd3,
        4'd2, 4'd3, 4'd8, 4'd4, 4'd6, 4'd2, 4'd6, 4'd4,
        4'd3, 4'd3, 4'd8, 4'd3, 4'd2, 4'd7, 4'd9, 4'd5
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        PASS  = 2'd2,
        FAIL  = 2'd3
    } chk_state_e;

    // A BCD digit above nine is an illegal code.
    function automatic logic is_bad_digit(input logic [DIGIT_W-1:0] d);
        return (d > 4'd9);
    endfunction

endpackage

// File: rtl/spigot_digit_sink_if.sv
// Digit stream handshake (producer side) and FIFO read port (reader side).
// master = producer/reader, slave = the sink.
interface spigot_digit_sink_if;

    logic                          in_valid;
    logic [spigot_pkg::DIGIT_W-1:0] in_digit;
    logic                          in_ready;
    logic                          rd_en;
    logic                          rd_valid;
    logic [spigot_pkg::DIGIT_W-1:0] rd_data;

    modport master (
        output in_valid, in_digit, rd_en,
        input  in_ready, rd_valid, rd_data
    );

    modport slave (
        input  in_valid, in_digit, rd_en,
        output in_ready, rd_valid, rd_data
    );

endinterface

// File: rtl/spigot_digit_sink_fifo.sv
// Synchronous first-word-fall-through FIFO; head entry is visible on rdata
// whenever not empty. Pointers carry one extra wrap bit.
module spigot_sink_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic         do_push_s;
    logic         do_pop_s;

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;
    assign rdata     = mem_q[rd_ptr_q[AW-1:0]];

    // Next storage contents and pointer values.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push_s) begin
            mem_d[wr_ptr_q[AW-1:0]] = wdata;
            wr_ptr_d                = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Storage and pointer registers; reset clears every entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/spigot_digit_sink.sv
// Spigot digit sink: handshake front end, FWFT buffer, saturating digit count,
// sticky illegal-code flag. Optional pi checker under SPIGOT_CHECK_EN.
module spigot_digit_sink
    import spigot_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    spigot_digit_sink_if.slave   io,
    output logic [CNT_W-1:0]     digit_count,
    output logic                 bad_digit
`ifdef SPIGOT_CHECK_EN
    ,
    output logic                 chk_pass,
    output logic                 chk_fail,
    output logic [4:0]           chk_index
`endif
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic               full_s;
    logic               empty_s;
    logic               accept_s;
    logic               pop_s;
    logic [DIGIT_W-1:0] head_s;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               bad_q, bad_d;

    // No pass-through: readiness depends only on occupancy.
    assign io.in_ready = ena & ~full_s;
    assign accept_s    = io.in_valid & ena & ~full_s;
    assign pop_s       = ena & io.rd_en & ~empty_s;
    assign io.rd_valid = ~empty_s;
    assign io.rd_data  = head_s;
    assign digit_count = count_q;
    assign bad_digit   = bad_q;

    spigot_sink_fifo #(
        .DEPTH (DEPTH),
        .W     (DIGIT_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept_s),
        .pop   (pop_s),
        .wdata (io.in_digit),
        .rdata (head_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // Saturating accept counter and sticky illegal-code flag.
    always_comb begin
        count_d = count_q;
        bad_d   = bad_q;
        if (accept_s && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_ONE;
        end else begin
            count_d = count_q;
        end
        if (accept_s && is_bad_digit(io.in_digit)) begin
            bad_d = 1'b1;
        end else begin
            bad_d = bad_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            bad_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            bad_q   <= bad_d;
        end
    end

`ifdef SPIGOT_CHECK_EN
    chk_state_e state_q, state_d;
    logic [4:0] idx_q, idx_d;
    logic       pass_q, pass_d;
    logic       fail_q, fail_d;
    logic       match_s;
    logic       active_s;

    // IDLE holds index 0, so the first accepted digit is compared immediately.
    assign match_s   = (io.in_digit == PI_DIGITS[idx_q]);
    assign active_s  = (state_q == IDLE) || (state_q == CHECK);
    assign chk_pass  = pass_q;
    assign chk_fail  = fail_q;
    assign chk_index = idx_q;

    // Checker state register with its registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 5'd0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
        end
    end

    // Next-state logic; PASS and FAIL are absorbing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, CHECK: begin
                if (!accept_s) begin
                    state_d = state_q;
                end else if (!match_s) begin
                    state_d = FAIL;
                end else if (idx_q == 5'd31) begin
                    state_d = PASS;
                end else begin
                    state_d = CHECK;
                end
            end
            PASS:    state_d = PASS;
            FAIL:    state_d = FAIL;
            default: state_d = IDLE;
        endcase
    end

    // Output logic; the index freezes on a mismatch and stays at 31 on pass.
    always_comb begin
        idx_d  = idx_q;
        pass_d = (state_d == PASS);
        fail_d = (state_d == FAIL);
        if (active_s && accept_s && match_s && (idx_q != 5'd31)) begin
            idx_d = idx_q + 5'd1;
        end else begin
            idx_d = idx_q;
        end
    end
`endif

endmodule

// File: tb/tb_spigot_digit_sink.sv
// Scoreboard bench for spigot_digit_sink: directed phases plus random traffic
// checked against a queue-based reference model sampled on the falling edge.
module tb_spigot_digit_sink;

    localparam int DEPTH = 8;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             ena = 1'b0;
    logic [CNT_W-1:0] digit_count;
    logic             bad_digit;
`ifdef SPIGOT_CHECK_EN
    logic             chk_pass;
    logic             chk_fail;
    logic [4:0]       chk_index;
`endif

    spigot_digit_sink_if io ();

    spigot_digit_sink #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .io          (io),
        .digit_count (digit_count),
        .bad_digit   (bad_digit)
`ifdef SPIGOT_CHECK_EN
        ,
        .chk_pass    (chk_pass),
        .chk_fail    (chk_fail),
        .chk_index   (chk_index)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    int pi_ref [32] = '{3,1,4,1,5,9,2,6,5,3,5,8,9,7,9,3,2,3,8,4,6,2,6,4,3,3,8,3,2,7,9,5};

    // reference model state
    logic [3:0] exp_q [$];
    int         hist [$];
    int         model_cnt = 0;
    bit         model_bad = 1'b0;
    bit         m_ready, m_pop, m_acc;
    bit         e_pass, e_fail;
    int         e_idx;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Expected checker outcome from the first 32 accepted digits since reset.
    function automatic void chk_expect(output bit p, output bit f, output int idx);
        f   = 1'b0;
        idx = hist.size();
        for (int i = 0; i < hist.size(); i++) begin
            if (!f && hist[i] != pi_ref[i]) begin
                f   = 1'b1;
                idx = i;
            end
        end
        p = !f && (hist.size() == 32);
    endfunction

    // Monitor: compare outputs against the model, then apply the coming edge.
    always @(negedge clk) begin
        chk_expect(e_pass, e_fail, e_idx);
        if (!rst_n) begin
            exp_q.delete();
            hist.delete();
            model_cnt = 0;
            model_bad = 1'b0;
            check("rst_rd_valid", io.rd_valid, 0);
            check("rst_rd_data", io.rd_data, 0);
            check("rst_in_ready", io.in_ready, ena);
            check("rst_count", digit_count, 0);
            check("rst_bad", bad_digit, 0);
`ifdef SPIGOT_CHECK_EN
            check("rst_chk_pass", chk_pass, 0);
            check("rst_chk_fail", chk_fail, 0);
            check("rst_chk_index", chk_index, 0);
`endif
        end else begin
            m_ready = ena && (exp_q.size() < DEPTH);
            check("in_ready", io.in_ready, m_ready);
            check("rd_valid", io.rd_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) check("rd_data", io.rd_data, exp_q[0]);
            check("digit_count", digit_count, model_cnt);
            check("bad_digit", bad_digit, model_bad);
`ifdef SPIGOT_CHECK_EN
            check("chk_pass", chk_pass, e_pass);
            check("chk_fail", chk_fail, e_fail);
            if (!e_pass) check("chk_index", chk_index, e_idx);
`endif
            m_pop = ena && io.rd_en && (exp_q.size() != 0);
            m_acc = io.in_valid && m_ready;
            if (m_pop) void'(exp_q.pop_front());
            if (m_acc) begin
                exp_q.push_back(io.in_digit);
                if (model_cnt < (1 << CNT_W) - 1) model_cnt++;
                if (io.in_digit > 9) model_bad = 1'b1;
                if (hist.size() < 32) hist.push_back(int'(io.in_digit));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Offer one digit and hold it until taken; rnd_pop randomises rd_en meanwhile.
    task automatic send(input int d, input bit rnd_pop);
        bit rdy;
        bit done;
        done = 1'b0;
        io.in_valid = 1'b1;
        io.in_digit = 4'(d);
        for (int t = 0; t < 200 && !done; t++) begin
            io.rd_en = rnd_pop ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            rdy = io.in_ready;
            cyc();
            done = rdy;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got not-ready expected accept of %0d", d);
        end
        io.in_valid = 1'b0;
        io.rd_en    = 1'b0;
    endtask

    task automatic pulse_rst();
        #2 rst_n = 1'b0;
        io.in_valid = 1'b0;
        io.rd_en    = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic drain();
        io.rd_en = 1'b1;
        repeat (DEPTH + 2) cyc();
        io.rd_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        io.in_valid = 1'b0;
        io.in_digit = 4'd0;
        io.rd_en    = 1'b0;
        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();
        ena = 1'b1;
        cyc();

        // in-order return of 3,1,4
        send(3, 1'b0);
        send(1, 1'b0);
        send(4, 1'b0);
        @(negedge clk);
        check("count_after_314", digit_count, 3);
        cyc();
        io.rd_en = 1'b1;
        repeat (3) cyc();
        io.rd_en = 1'b0;
        @(negedge clk);
        check("empty_after_3_pops", io.rd_valid, 0);
        cyc();

        // fill to DEPTH, hold the ninth, pop-while-full does the pop only
        io.in_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            io.in_digit = 4'(i + 1);
            cyc();
        end
        io.in_digit = 4'd9;
        cyc();
        @(negedge clk);
        check("full_not_ready", io.in_ready, 0);
        cyc();
        io.rd_en = 1'b1;
        cyc();
        io.rd_en = 1'b0;
        @(negedge clk);
        check("ready_after_pop", io.in_ready, 1);
        cyc();
        io.in_valid = 1'b0;
        drain();

        // illegal code is stored and flagged
        send(12, 1'b0);
        @(negedge clk);
        check("bad_set", bad_digit, 1);
        check("bad_data", io.rd_data, 12);
        cyc();
        drain();
        send(5, 1'b1);
        drain();

        // full pi stream
        pulse_rst();
        for (int i = 0; i < 32; i++) send(pi_ref[i], 1'b1);
        drain();
`ifdef SPIGOT_CHECK_EN
        @(negedge clk);
        check("pi_pass", chk_pass, 1);
        check("pi_no_fail", chk_fail, 0);
        cyc();
`endif

        // wrong fourth digit, then a correct stream
        pulse_rst();
        send(3, 1'b1);
        send(1, 1'b1);
        send(4, 1'b1);
        send(2, 1'b1);
        for (int i = 0; i < 32; i++) send(pi_ref[i], 1'b1);
        drain();
`ifdef SPIGOT_CHECK_EN
        @(negedge clk);
        check("mismatch_fail", chk_fail, 1);
        check("mismatch_index", chk_index, 3);
        check("mismatch_no_pass", chk_pass, 0);
        cyc();
`endif

        // random traffic with an asynchronous reset in the middle
        pulse_rst();
        for (int i = 0; i < 400; i++) begin
            if (i == 200) pulse_rst();
            ena         = ($urandom_range(0, 7) != 0);
            io.in_valid = 1'($urandom_range(0, 1));
            io.in_digit = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                      : 4'($urandom_range(0, 9));
            io.rd_en    = ($urandom_range(0, 2) != 0);
            cyc();
        end
        ena = 1'b1;
        io.in_valid = 1'b0;
        drain();

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
